// File: rtl/ram_sp_fifo_ctrl_pkg.sv
// ram_sp_fifo_ctrl_pkg
//   Shared definitions for the single-port RAM FIFO controller:
//   RAM geometry constants and the read/write arbiter priority encoding.
package ram_sp_fifo_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH_1536 = 1536;
  localparam int unsigned FIFO_ADR_WD_11  = 11;

  // Arbiter priority: which side wins the next contended cycle.
  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } pri_e;

endpackage

// File: rtl/fifo_obuf_2x32.sv
// fifo_obuf_2x32
//   Two-entry output buffer in front of the pop stream. Absorbs the one-cycle
//   RAM read latency and downstream backpressure.
//   Ports:
//     clk, rstn         clock, async active-low reset
//     flush_i           synchronous clear
//     cap_i, cap_dat_i  capture returning RAM read data into the tail
//     pop_i             remove head (caller guarantees cnt_o != 0)
//     val_o, dat_o      head valid / registered head data
//     cnt_o             entries held (0..2)
module fifo_obuf_2x32 #(
  parameter int unsigned DAT_WD = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              cap_i,
  input  logic [DAT_WD-1:0] cap_dat_i,
  input  logic              pop_i,
  output logic              val_o,
  output logic [DAT_WD-1:0] dat_o,
  output logic [1:0]        cnt_o
);

  logic [DAT_WD-1:0] head;
  logic [DAT_WD-1:0] tail;
  logic [1:0]        cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      case ({pop_i, cap_i})
        2'b10: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) head <= cap_dat_i;
          else             tail <= cap_dat_i;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          // Pop and capture together: occupancy unchanged, order kept.
          if (cnt == 2'd2) begin
            head <= tail;
            tail <= cap_dat_i;
          end else begin
            head <= cap_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign val_o = (cnt != 2'd0);
  assign dat_o = head;
  assign cnt_o = cnt;

endmodule

// File: rtl/ram_sp_fifo_ctrl.sv
// ram_sp_fifo_ctrl
//   Drives a single-port RAM as a FIFO: one RAM access per cycle, read data
//   returns the cycle after the read. Holds pointers, occupancy counters, the
//   read/write arbiter and a 2-entry output buffer.
//   Ports:
//     clk, rstn                  clock, async active-low reset
//     flush_i                    synchronous clear of all FIFO state
//     wr_val_i/wr_dat_i/wr_rdy_o push stream
//     rd_val_o/rd_dat_o/rd_rdy_i pop stream
//     cnt_o                      words held (RAM + in flight + output buffer)
//     ram_*                      RAM macro interface
module ram_sp_fifo_ctrl
  import ram_sp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DAT_WD = 32,
  parameter int unsigned ADR_WD = FIFO_ADR_WD_11,
  parameter int unsigned DEPTH  = FIFO_DEPTH_1536,
  parameter int unsigned CNT_WD = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              wr_val_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_rdy_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  input  logic              rd_rdy_i,
  output logic [CNT_WD-1:0] cnt_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  logic [ADR_WD-1:0] wr_ptr;
  logic [ADR_WD-1:0] rd_ptr;
  logic [CNT_WD-1:0] ram_cnt;
  logic [CNT_WD-1:0] ram_cnt_nxt;
  logic [CNT_WD-1:0] cnt_q;
  logic              inflight;
  pri_e              pri;

  logic [1:0] buf_cnt;
  logic [1:0] buf_left;
  logic [1:0] buf_nxt;
  logic       full;
  logic       pop;
  logic       cap;
  logic       rd_want;
  logic       wr_want;
  logic       contend;
  logic       rd_grant;
  logic       wr_grant;

  // DEPTH is not a power of two, so the pointer wraps explicitly.
  function automatic logic [ADR_WD-1:0] ptr_inc(input logic [ADR_WD-1:0] p);
    return (p == ADR_WD'(DEPTH - 1)) ? '0 : p + ADR_WD'(1);
  endfunction

  always_comb begin
    full     = (ram_cnt == CNT_WD'(DEPTH));
    pop      = rd_val_o && rd_rdy_i;
    buf_left = buf_cnt - {1'b0, pop};
    // Only issue a read if the buffer can take it once the in-flight word lands.
    rd_want  = (ram_cnt != '0) && ((buf_left + {1'b0, inflight}) < 2'd2);
    wr_want  = wr_val_i && !full;
    contend  = rd_want && wr_want;
    rd_grant = !flush_i && rd_want && (!wr_want || (pri == PRI_RD));
    // rstn gate keeps the write strobe low while the part is held in reset.
    wr_grant = rstn && !flush_i && wr_want && (!rd_want || (pri == PRI_WR));
    cap      = inflight && !flush_i;
    buf_nxt  = buf_left + {1'b0, cap};
    ram_cnt_nxt = ram_cnt + CNT_WD'(wr_grant) - CNT_WD'(rd_grant);
  end

  assign wr_rdy_o     = !full && !rd_grant && !flush_i;
  assign ram_wr_ena_o = wr_grant;
  assign ram_rd_ena_o = rd_grant;
  assign ram_adr_o    = wr_grant ? wr_ptr : rd_ptr;
  assign ram_wr_dat_o = wr_dat_i;
  assign cnt_o        = cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      pri      <= PRI_RD;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      pri      <= PRI_RD;
      cnt_q    <= '0;
    end else begin
      if (wr_grant) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_grant) rd_ptr <= ptr_inc(rd_ptr);
      ram_cnt  <= ram_cnt_nxt;
      inflight <= rd_grant;
      if (contend) pri <= (pri == PRI_RD) ? PRI_WR : PRI_RD;
      // Register the post-edge total so cnt_o is glitch-free.
      cnt_q <= ram_cnt_nxt + CNT_WD'(rd_grant) + CNT_WD'(buf_nxt);
    end
  end

  fifo_obuf_2x32 #(
    .DAT_WD (DAT_WD)
  ) u_obuf (
    .clk       (clk),
    .rstn      (rstn),
    .flush_i   (flush_i),
    .cap_i     (cap),
    .cap_dat_i (ram_rd_dat_i),
    .pop_i     (pop),
    .val_o     (rd_val_o),
    .dat_o     (rd_dat_o),
    .cnt_o     (buf_cnt)
  );

endmodule
